// File: rtl/ram8_sweep_if.sv
// rtl/ram8_sweep_if.sv - Data, load and clear handshake bundle for the 8-word register bank.
interface ram8_sweep_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic [2:0]       address;
  logic             clear_req;
  logic [WIDTH-1:0] out;
  logic             ready;
  logic             busy;
  logic [7:0]       written;

  modport master (
    output in, load, address, clear_req,
    input  out, ready, busy, written
  );

  modport slave (
    input  in, load, address, clear_req,
    output out, ready, busy, written
  );
endinterface

// File: rtl/ram8_sweep.sv
// rtl/ram8_sweep.sv - 8-word register bank with one-hot load decode, combinational read and a sequenced clear sweep.
module ram8_sweep #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  ram8_sweep_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       cnt;
  logic [2:0]       cnt_nxt;
  logic [WIDTH-1:0] mem [8];
  logic [7:0]       written;
  logic [7:0]       load_sel;
  logic [7:0]       clr_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Load and clear selects are mutually exclusive: loads only decode in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_sel  = 8'h00;
    clr_sel   = 8'h00;
    case (state)
      IDLE: begin
        if (bus.load) begin
          load_sel = 8'd1 << bus.address;
        end
        if (bus.clear_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = 3'd0;
        end
      end
      CLEAR: begin
        clr_sel = 8'd1 << cnt;
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mem[i] <= '0;
      end
      written <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (clr_sel[i]) begin
          mem[i] <= CLR_VALUE;
        end else if (load_sel[i]) begin
          mem[i] <= bus.in;
        end
      end
      written <= (written | load_sel) & ~clr_sel;
    end
  end

  assign bus.out     = mem[bus.address];
  assign bus.ready   = (state == IDLE);
  assign bus.busy    = (state == CLEAR);
  assign bus.written = written;

endmodule

// File: tb/tb_ram8_sweep.sv
// tb/tb_ram8_sweep.sv - Table, directed and randomized checks of ram8_sweep against a behavioural bank model.
module tb_ram8_sweep;

  logic clk;
  logic rst_n;

  ram8_sweep_if #(.WIDTH(16)) bus0 ();
  ram8_sweep_if #(.WIDTH(16)) bus1 ();

  ram8_sweep #(.WIDTH(16), .CLR_VALUE(16'h0000)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  ram8_sweep #(.WIDTH(16), .CLR_VALUE(16'hFFFF)) u_dut_ff (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_mem [8];
  logic [7:0]  m_written;
  int          m_sweep_left;

  typedef struct {
    logic        load;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        clr;
    logic [15:0] exp_out;
    logic [7:0]  exp_written;
    logic        exp_ready;
  } vec_t;

  vec_t vecs [10];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
    m_written    = 8'h00;
    m_sweep_left = 0;
  endfunction

  // A sweep is "8 edges remaining"; the word it hits is the number already done.
  function automatic void model_edge();
    int idx;
    if (m_sweep_left > 0) begin
      idx = 8 - m_sweep_left;
      m_mem[idx] = 16'h0000;
      m_written[idx] = 1'b0;
      m_sweep_left--;
    end else begin
      if (bus0.load) begin
        m_mem[bus0.address] = bus0.in;
        m_written[bus0.address] = 1'b1;
      end
      if (bus0.clear_req) m_sweep_left = 8;
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(string name);
    chk({name, "_out"}, {16'h0, bus0.out}, {16'h0, m_mem[bus0.address]});
    chk({name, "_ready"}, {31'h0, bus0.ready}, {31'h0, m_sweep_left == 0});
    chk({name, "_busy"}, {31'h0, bus0.busy}, {31'h0, m_sweep_left != 0});
    chk({name, "_written"}, {24'h0, bus0.written}, {24'h0, m_written});
  endtask

  task automatic wait_ready(string name);
    int n = 0;
    while (bus0.ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_ready_timeout"}, {31'h0, bus0.ready}, 32'h1);
  endtask

  task automatic check_all_words(string name, logic [15:0] exp);
    for (int a = 0; a < 8; a++) begin
      bus0.address = a[2:0];
      #1;
      chk($sformatf("%s_word%0d", name, a), {16'h0, bus0.out}, {16'h0, exp});
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd3, 16'h1234, 1'b0, 16'h1234, 8'h08, 1'b1};
    vecs[1] = '{1'b1, 3'd6, 16'hBEEF, 1'b0, 16'hBEEF, 8'h48, 1'b1};
    vecs[2] = '{1'b0, 3'd0, 16'hFFFF, 1'b0, 16'h0000, 8'h48, 1'b1};
    vecs[3] = '{1'b0, 3'd1, 16'hFFFF, 1'b0, 16'h0000, 8'h48, 1'b1};
    vecs[4] = '{1'b0, 3'd2, 16'hFFFF, 1'b0, 16'h0000, 8'h48, 1'b1};
    vecs[5] = '{1'b0, 3'd3, 16'hFFFF, 1'b0, 16'h1234, 8'h48, 1'b1};
    vecs[6] = '{1'b0, 3'd4, 16'hFFFF, 1'b0, 16'h0000, 8'h48, 1'b1};
    vecs[7] = '{1'b0, 3'd5, 16'hFFFF, 1'b0, 16'h0000, 8'h48, 1'b1};
    vecs[8] = '{1'b0, 3'd6, 16'hFFFF, 1'b0, 16'hBEEF, 8'h48, 1'b1};
    vecs[9] = '{1'b0, 3'd7, 16'hFFFF, 1'b0, 16'h0000, 8'h48, 1'b1};

    rst_n = 1'b0;
    bus0.in = '0; bus0.load = 1'b0; bus0.address = 3'd0; bus0.clear_req = 1'b0;
    bus1.in = '0; bus1.load = 1'b0; bus1.address = 3'd0; bus1.clear_req = 1'b0;
    model_reset();
    #5;
    chk("reset_ready", {31'h0, bus0.ready}, 32'h1);
    chk("reset_busy", {31'h0, bus0.busy}, 32'h0);
    chk("reset_written", {24'h0, bus0.written}, 32'h0);
    chk("reset_out", {16'h0, bus0.out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: two writes, then read back every address.
    for (int v = 0; v < 10; v++) begin
      bus0.load = vecs[v].load;
      bus0.address = vecs[v].addr;
      bus0.in = vecs[v].data;
      bus0.clear_req = vecs[v].clr;
      tick();
      chk($sformatf("vec%0d_out", v), {16'h0, bus0.out}, {16'h0, vecs[v].exp_out});
      chk($sformatf("vec%0d_written", v), {24'h0, bus0.written}, {24'h0, vecs[v].exp_written});
      chk($sformatf("vec%0d_ready", v), {31'h0, bus0.ready}, {31'h0, vecs[v].exp_ready});
      check_model($sformatf("vec%0d_model", v));
    end

    // Sweep observed from address 6.
    bus0.address = 3'd6;
    bus0.clear_req = 1'b1;
    tick();
    bus0.clear_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("sweep_busy%0d", k), {31'h0, bus0.busy}, 32'h1);
      chk($sformatf("sweep_out6_%0d", k), {16'h0, bus0.out}, (k >= 7) ? 32'h0 : 32'hBEEF);
      tick();
    end
    chk("sweep_done_ready", {31'h0, bus0.ready}, 32'h1);
    chk("sweep_done_written", {24'h0, bus0.written}, 32'h0);
    check_all_words("sweep_done", 16'h0000);

    // Load attempted mid-sweep is dropped.
    bus0.clear_req = 1'b1;
    tick();
    bus0.clear_req = 1'b0;
    tick(); tick();
    bus0.load = 1'b1; bus0.address = 3'd7; bus0.in = 16'hAAAA;
    tick();
    bus0.load = 1'b0;
    check_model("midload");
    wait_ready("midload");
    bus0.address = 3'd7;
    #1;
    chk("midload_word7", {16'h0, bus0.out}, 32'h0);
    chk("midload_written7", {31'h0, bus0.written[7]}, 32'h0);

    // Load and clear on the same IDLE edge.
    bus0.load = 1'b1; bus0.address = 3'd0; bus0.in = 16'h5555; bus0.clear_req = 1'b1;
    tick();
    bus0.load = 1'b0; bus0.clear_req = 1'b0;
    chk("same_edge_out", {16'h0, bus0.out}, 32'h5555);
    chk("same_edge_busy", {31'h0, bus0.busy}, 32'h1);
    wait_ready("same_edge");
    chk("same_edge_word0", {16'h0, bus0.out}, 32'h0);
    chk("same_edge_written", {24'h0, bus0.written}, 32'h0);

    // Async reset mid-sweep.
    bus0.load = 1'b1; bus0.address = 3'd2; bus0.in = 16'h1111;
    tick();
    bus0.load = 1'b0; bus0.clear_req = 1'b1;
    tick();
    bus0.clear_req = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_ready", {31'h0, bus0.ready}, 32'h1);
    chk("arst_busy", {31'h0, bus0.busy}, 32'h0);
    chk("arst_written", {24'h0, bus0.written}, 32'h0);
    check_all_words("arst", 16'h0000);
    rst_n = 1'b1;
    tick();
    check_model("arst_after");

    // clear_req held on the FFFF instance: back-to-back sweeps, one IDLE gap.
    bus1.clear_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk($sformatf("held_busy_e%0d", n), {31'h0, bus1.busy}, {31'h0, (n % 9) != 0});
    end
    bus1.clear_req = 1'b0;
    begin
      int n = 0;
      while (bus1.ready !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("held_ready_timeout", {31'h0, bus1.ready}, 32'h1);
    end
    for (int a = 0; a < 8; a++) begin
      bus1.address = a[2:0];
      #1;
      chk($sformatf("held_word%0d", a), {16'h0, bus1.out}, 32'hFFFF);
    end
    chk("held_written", {24'h0, bus1.written}, 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      bus0.load = 1'($urandom_range(0, 1));
      bus0.address = 3'($urandom_range(0, 7));
      bus0.in = 16'($urandom);
      bus0.clear_req = ($urandom_range(0, 15) == 0);
      tick();
      check_model($sformatf("rand%0d", c));
      bus0.address = 3'($urandom_range(0, 7));
      #1;
      chk($sformatf("rand%0d_reread", c), {16'h0, bus0.out}, {16'h0, m_mem[bus0.address]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
